// File: rtl/apu_tok_ocpl_if.sv
// OCP-lite command port between the APU token producer and the NoC token
// initiator: address/command/data from the master, command accept back.
interface apu_tok_ocpl_if;
  logic [7:0] m_maddr;
  logic [2:0] m_mcmd;
  logic [7:0] m_mdata;
  logic       s_cmdaccept;

  modport master (
    output m_maddr,
    output m_mcmd,
    output m_mdata,
    input  s_cmdaccept
  );

  modport slave (
    input  m_maddr,
    input  m_mcmd,
    input  m_mdata,
    output s_cmdaccept
  );
endinterface

// File: rtl/apu_tok_ocpl_init.sv
// APU token producer front-end. Token pulses are accumulated in per-channel
// saturating counters. Non-empty channels are served round-robin, one
// OCP-lite WR per grant, and each WR carries a batch of up to MAX_BATCH
// tokens. An idle/flush handshake lets the NoC power controller quiesce the
// block.
module apu_tok_ocpl_init #(
  parameter int         N_CH      = 4,
  parameter int         CNT_W     = 6,
  parameter int         MAX_BATCH = 8,
  parameter logic [7:0] BASE_ADDR = 8'h00
) (
  input  logic            i_apu_x_clk,
  input  logic            i_apu_x_rst,
  input  logic            i_en,
  input  logic [N_CH-1:0] i_tok_prod,
  output logic [N_CH-1:0] o_tok_ovf,
  input  logic            i_tok_ovf_clr,
  apu_tok_ocpl_if.master  apu_init_tok,
  input  logic            i_apu_pwr_tok_idle_req,
  output logic            o_apu_pwr_tok_idle_ack,
  output logic            o_apu_pwr_tok_idle_val
);

  localparam int             CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT   = '1;
  localparam logic [CNT_W-1:0] MAX_BATCH_C = CNT_W'(MAX_BATCH);
  localparam logic [2:0]     CMD_IDLE    = 3'b000;
  localparam logic [2:0]     CMD_WR      = 3'b001;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_CMD  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt     [N_CH];
  logic [CNT_W-1:0] w_cnt_nxt [N_CH];
  logic [CH_W-1:0]  r_rr, w_rr_nxt;
  logic [CH_W-1:0]  r_g_ch, w_g_ch_nxt;
  logic [CNT_W-1:0] r_batch, w_batch_nxt;
  logic [7:0]       r_maddr, w_maddr_nxt;
  logic [7:0]       r_mdata, w_mdata_nxt;
  logic [2:0]       r_mcmd, w_mcmd_nxt;
  logic [N_CH-1:0]  r_ovf, w_ovf_set;
  logic             r_ack, r_val;
  logic             w_acc;
  logic             w_found;
  logic [CH_W-1:0]  w_sel;
  logic [CNT_W-1:0] w_sel_cnt, w_batch;
  logic [CNT_W-1:0] w_base;
  logic             w_all_zero;
  int               w_idx;

  // Round-robin search: first non-empty channel at or after the pointer.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = 0;
    for (int k = 0; k < N_CH; k++) begin
      w_idx = int'(r_rr) + k;
      if (w_idx >= N_CH) begin
        w_idx = w_idx - N_CH;
      end else begin
        w_idx = w_idx;
      end
      if (!w_found && (r_cnt[CH_W'(w_idx)] != '0)) begin
        w_found = 1'b1;
        w_sel   = CH_W'(w_idx);
      end else begin
        w_found = w_found;
      end
    end
    w_sel_cnt = r_cnt[w_sel];
    w_batch   = (w_sel_cnt > MAX_BATCH_C) ? MAX_BATCH_C : w_sel_cnt;
  end

  // FSM state register.
  always_ff @(posedge i_apu_x_clk) begin
    if (i_apu_x_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state plus next values of the grant and registered bus outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr;
    w_g_ch_nxt  = r_g_ch;
    w_batch_nxt = r_batch;
    w_maddr_nxt = r_maddr;
    w_mdata_nxt = r_mdata;
    w_mcmd_nxt  = r_mcmd;
    w_acc       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_en && !i_apu_pwr_tok_idle_req && w_found) begin
          w_state_nxt = S_CMD;
          w_g_ch_nxt  = w_sel;
          w_batch_nxt = w_batch;
          w_maddr_nxt = BASE_ADDR + 8'(w_sel);
          w_mdata_nxt = 8'(w_batch);
          w_mcmd_nxt  = CMD_WR;
        end else begin
          w_mcmd_nxt  = CMD_IDLE;
        end
      end
      S_CMD: begin
        // The command stays up until accepted, regardless of i_en / idle_req.
        if (apu_init_tok.s_cmdaccept) begin
          w_acc       = 1'b1;
          w_state_nxt = S_IDLE;
          w_rr_nxt    = (r_g_ch == CH_W'(N_CH - 1)) ? '0 : r_g_ch + CH_W'(1);
          w_maddr_nxt = 8'h00;
          w_mdata_nxt = 8'h00;
          w_mcmd_nxt  = CMD_IDLE;
        end else begin
          w_mcmd_nxt  = CMD_WR;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_mcmd_nxt  = CMD_IDLE;
      end
    endcase
  end

  // Counter update: decrement first, then saturation is judged on the net value.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_ovf_set  = '0;
    w_all_zero = 1'b1;
    w_base     = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (w_acc && (r_g_ch == CH_W'(c))) begin
        w_base = r_cnt[c] - r_batch;
      end else begin
        w_base = r_cnt[c];
      end
      if (i_tok_prod[c] && (w_base == MAX_CNT)) begin
        w_cnt_nxt[c] = w_base;
        w_ovf_set[c] = 1'b1;
      end else if (i_tok_prod[c]) begin
        w_cnt_nxt[c] = w_base + CNT_W'(1);
      end else begin
        w_cnt_nxt[c] = w_base;
      end
      if (w_cnt_nxt[c] != '0) begin
        w_all_zero = 1'b0;
      end else begin
        w_all_zero = w_all_zero;
      end
    end
  end

  // Datapath registers: counters, grant latch, bus outputs, sticky flags, idle handshake.
  always_ff @(posedge i_apu_x_clk) begin
    if (i_apu_x_rst) begin
      for (int c = 0; c < N_CH; c++) begin
        r_cnt[c] <= '0;
      end
      r_rr    <= '0;
      r_g_ch  <= '0;
      r_batch <= '0;
      r_maddr <= 8'h00;
      r_mdata <= 8'h00;
      r_mcmd  <= CMD_IDLE;
      r_ovf   <= '0;
      r_ack   <= 1'b0;
      r_val   <= 1'b1;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_rr    <= w_rr_nxt;
      r_g_ch  <= w_g_ch_nxt;
      r_batch <= w_batch_nxt;
      r_maddr <= w_maddr_nxt;
      r_mdata <= w_mdata_nxt;
      r_mcmd  <= w_mcmd_nxt;
      // A new overflow wins over a simultaneous clear.
      r_ovf   <= (r_ovf & ~{N_CH{i_tok_ovf_clr}}) | w_ovf_set;
      r_ack   <= i_apu_pwr_tok_idle_req & (w_state_nxt == S_IDLE);
      r_val   <= (w_state_nxt == S_IDLE) & w_all_zero;
    end
  end

  assign apu_init_tok.m_maddr = r_maddr;
  assign apu_init_tok.m_mdata = r_mdata;
  assign apu_init_tok.m_mcmd  = r_mcmd;
  assign o_tok_ovf              = r_ovf;
  assign o_apu_pwr_tok_idle_ack = r_ack;
  assign o_apu_pwr_tok_idle_val = r_val;

endmodule

// File: tb/tb_apu_tok_ocpl_init.sv
// Self-checking bench for apu_tok_ocpl_init. Expected WR commands are queued
// when tokens are injected and compared as the DUT's commands are accepted.
module tb_apu_tok_ocpl_init;

  localparam int         N_CH = 4;
  localparam logic [7:0] BASE = 8'hFE;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en  = 1'b0;
  logic            clr = 1'b0;
  logic            req = 1'b0;
  logic [N_CH-1:0] tok = '0;
  logic [N_CH-1:0] ovf;
  logic            ack;
  logic            val;

  apu_tok_ocpl_if u_if ();

  apu_tok_ocpl_init #(
    .N_CH      (N_CH),
    .CNT_W     (6),
    .MAX_BATCH (8),
    .BASE_ADDR (BASE)
  ) u_dut (
    .i_apu_x_clk            (clk),
    .i_apu_x_rst            (rst),
    .i_en                   (en),
    .i_tok_prod             (tok),
    .o_tok_ovf              (ovf),
    .i_tok_ovf_clr          (clr),
    .apu_init_tok           (u_if),
    .i_apu_pwr_tok_idle_req (req),
    .o_apu_pwr_tok_idle_ack (ack),
    .o_apu_pwr_tok_idle_val (val)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [15:0] exp_q[$];
  logic [15:0] sb_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [7:0] addr_of(input int c);
    return BASE + 8'(c);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [N_CH-1:0] mask, input int n);
    tok = mask;
    repeat (n) tick();
    tok = '0;
  endtask

  task automatic push_wr(input int c, input int n);
    exp_q.push_back({addr_of(c), 8'(n)});
  endtask

  task automatic wait_q(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && exp_q.size() > target; i++) tick();
    chk(tag, 32'(exp_q.size()), 32'(target));
  endtask

  // Scoreboard: every accepted WR must match the oldest expected command.
  always @(negedge clk) begin
    if (!rst && u_if.m_mcmd == 3'b001 && u_if.s_cmdaccept) begin
      if (exp_q.size() == 0) begin
        chk("sb_extra_wr", 32'(exp_q.size()), 32'd1);
      end else begin
        sb_e = exp_q.pop_front();
        chk("wr_maddr", 32'(u_if.m_maddr), 32'(sb_e[15:8]));
        chk("wr_mdata", 32'(u_if.m_mdata), 32'(sb_e[7:0]));
      end
    end
  end

  initial begin
    u_if.s_cmdaccept = 1'b1;
    tick();
    tick();
    // Reset state
    chk("rst_mcmd",  32'(u_if.m_mcmd),  32'd0);
    chk("rst_maddr", 32'(u_if.m_maddr), 32'd0);
    chk("rst_mdata", 32'(u_if.m_mdata), 32'd0);
    chk("rst_ack",   32'(ack),          32'd0);
    chk("rst_val",   32'(val),          32'd1);
    chk("rst_ovf",   32'(ovf),          32'd0);
    rst = 1'b0;
    en  = 1'b1;
    tick();

    // Single token on ch2: WR two cycles later, channel address wraps mod 256
    tok = 4'b0100;
    push_wr(2, 1);
    tick();
    tok = '0;
    chk("t1_lat_mcmd", 32'(u_if.m_mcmd), 32'd0);
    chk("t1_lat_val",  32'(val),         32'd0);
    tick();
    chk("t1_mcmd",  32'(u_if.m_mcmd),  32'd1);
    chk("t1_maddr", 32'(u_if.m_maddr), 32'(addr_of(2)));
    chk("t1_mdata", 32'(u_if.m_mdata), 32'd1);
    tick();
    chk("t1_done_mcmd", 32'(u_if.m_mcmd), 32'd0);
    chk("t1_done_val",  32'(val),         32'd1);

    // Backpressure: ch0 holding 3, accept low for 5 cycles
    en = 1'b0;
    pulse(4'b0001, 3);
    u_if.s_cmdaccept = 1'b0;
    en = 1'b1;
    push_wr(0, 3);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_mcmd",  32'(u_if.m_mcmd),  32'd1);
      chk("t2_hold_maddr", 32'(u_if.m_maddr), 32'(addr_of(0)));
      chk("t2_hold_mdata", 32'(u_if.m_mdata), 32'd3);
      if (i == 4) u_if.s_cmdaccept = 1'b1;
      tick();
    end
    chk("t2_done_mcmd", 32'(u_if.m_mcmd), 32'd0);
    chk("t2_done_val",  32'(val),         32'd1);

    // Round-robin from pointer 0: 0,1,3 then refilled ch0 after ch3
    rst = 1'b1;
    tick();
    rst = 1'b0;
    en  = 1'b0;
    pulse(4'b1011, 1);
    push_wr(0, 1);
    push_wr(1, 1);
    push_wr(3, 1);
    en = 1'b1;
    wait_q("t3_first", 2, 20);
    pulse(4'b0001, 1);
    push_wr(0, 1);
    wait_q("t3_drain", 0, 40);
    tick();
    tick();
    chk("t3_val", 32'(val), 32'd1);

    // Saturation: 70 pulses on ch1, then drain as 7x8 + 7
    en = 1'b0;
    pulse(4'b0010, 70);
    chk("t4_ovf_set", 32'(ovf), 32'h2);
    chk("t4_val_busy", 32'(val), 32'd0);
    tok = 4'b0010;
    clr = 1'b1;
    tick();
    tok = '0;
    chk("t4_clr_vs_set", 32'(ovf), 32'h2);
    tick();
    clr = 1'b0;
    chk("t4_clr", 32'(ovf), 32'h0);
    for (int i = 0; i < 7; i++) push_wr(1, 8);
    push_wr(1, 7);
    en = 1'b1;
    wait_q("t4_drain", 0, 60);
    tick();
    tick();
    chk("t4_val", 32'(val), 32'd1);
    chk("t4_ovf_end", 32'(ovf), 32'h0);

    // Token arriving in the accept cycle of the same channel
    en = 1'b0;
    pulse(4'b0001, 2);
    push_wr(0, 2);
    u_if.s_cmdaccept = 1'b0;
    en = 1'b1;
    tick();
    tick();
    chk("t5_mcmd",  32'(u_if.m_mcmd),  32'd1);
    chk("t5_mdata", 32'(u_if.m_mdata), 32'd2);
    tok = 4'b0001;
    u_if.s_cmdaccept = 1'b1;
    push_wr(0, 1);
    tick();
    tok = '0;
    wait_q("t5_drain", 0, 20);
    tick();
    chk("t5_ovf", 32'(ovf), 32'h0);
    chk("t5_val", 32'(val), 32'd1);

    // Idle handshake raised during S_CMD with accept delayed 3 cycles
    en = 1'b0;
    pulse(4'b0010, 1);
    push_wr(1, 1);
    u_if.s_cmdaccept = 1'b0;
    en = 1'b1;
    tick();
    tick();
    tok = 4'b0100;
    req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t6_ack_cmd",  32'(ack),         32'd0);
      chk("t6_mcmd_cmd", 32'(u_if.m_mcmd), 32'd1);
      tick();
      tok = '0;
    end
    u_if.s_cmdaccept = 1'b1;
    chk("t6_ack_acc", 32'(ack), 32'd0);
    tick();
    chk("t6_ack_rise", 32'(ack),         32'd1);
    chk("t6_mcmd_idl", 32'(u_if.m_mcmd), 32'd0);
    chk("t6_val_pend", 32'(val),         32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_no_wr",   32'(u_if.m_mcmd), 32'd0);
      chk("t6_ack_hold", 32'(ack),        32'd1);
    end
    push_wr(2, 1);
    req = 1'b0;
    tick();
    chk("t6_ack_fall", 32'(ack),          32'd0);
    chk("t6_wr_after", 32'(u_if.m_mcmd),  32'd1);
    chk("t6_wr_addr",  32'(u_if.m_maddr), 32'(addr_of(2)));
    wait_q("t6_drain", 0, 20);

    // Reset while a command is outstanding: dropped, not retried
    tick();
    en = 1'b0;
    pulse(4'b1000, 1);
    u_if.s_cmdaccept = 1'b0;
    en = 1'b1;
    tick();
    tick();
    chk("t7_wr", 32'(u_if.m_mcmd), 32'd1);
    rst = 1'b1;
    tick();
    chk("t7_rst_mcmd",  32'(u_if.m_mcmd),  32'd0);
    chk("t7_rst_val",   32'(val),          32'd1);
    chk("t7_rst_maddr", 32'(u_if.m_maddr), 32'd0);
    chk("t7_rst_mdata", 32'(u_if.m_mdata), 32'd0);
    rst = 1'b0;
    u_if.s_cmdaccept = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t7_no_retry", 32'(u_if.m_mcmd), 32'd0);
    end
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
